add_share_arbiter: RTL and testbench

Two-requester arbiter that time-shares one WIDTH-bit ripple adder. The adder sits behind a 2:1 operand mux. The block accepts an operand pair from one requester at a time over a valid/ready handshake. It steers the operands through the mux into the shared adder, registers the sum, and returns it with a requester ID on a valid/ready response port. It is the sequencing layer above the adder/mux datapath cells in this library.

---
 rtl/add_share_arbiter.sv | 117 +++++++++++
 tb/tb_add_share_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/add_share_arbiter.sv
// add_share_arbiter: two requesters time-share one ripple adder.
// Operands are captured per requester slot, steered through a 2:1 mux by the
// registered owner ID, added, and the sum is returned on a held response port.
// Build option: define ADD_SHARE_ARB_FIXED_PRIO_EN for fixed priority (req0
// wins every tie); default is round-robin on the `last` pointer.
module add_share_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_id
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
    } req_t;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state;
    logic            last;
    logic            id_q;
    req_t [1:0]      op_q;
    req_t [1:0]      req_in;
    req_t            mux_op;
    logic            pick0;
    logic            gnt0;
    logic            gnt1;
    logic [WIDTH:0]  carry;
    logic [WIDTH-1:0] sum_w;

    assign req_in[0] = {req0_a, req0_b, req0_cin};
    assign req_in[1] = {req1_a, req1_b, req1_cin};

    // Tie-break choice: requester 0 wins a tie when it was not served last
    // (or always, in the fixed-priority build).
`ifdef ADD_SHARE_ARB_FIXED_PRIO_EN
    assign pick0 = 1'b1;
`else
    assign pick0 = last;
`endif

    // Grant from the valids; at most one grant is ever asserted.
    always_comb begin
        gnt0 = req0_valid & (~req1_valid | pick0);
        gnt1 = req1_valid & ~gnt0;
    end

    assign req0_ready = (state == IDLE) & gnt0 & ~rst;
    assign req1_ready = (state == IDLE) & gnt1 & ~rst;

    // Shared datapath: operand mux selected by the owner, then a ripple chain.
    assign mux_op   = op_q[id_q];
    assign carry[0] = mux_op.cin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_rca
        assign sum_w[i]   = mux_op.a[i] ^ mux_op.b[i] ^ carry[i];
        assign carry[i+1] = (mux_op.a[i] & mux_op.b[i]) |
                            (carry[i] & (mux_op.a[i] ^ mux_op.b[i]));
    end

    // Sequencer: capture on request handshake, register the sum, hold it
    // until the consumer takes it. Reset discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            id_q      <= 1'b0;
            op_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready | req1_ready) begin
                        id_q       <= gnt1;
                        op_q[gnt1] <= req_in[gnt1];
                        last       <= gnt1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_sum   <= sum_w;
                    rsp_cout  <= carry[WIDTH];
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_share_arbiter.sv
// tb_add_share_arbiter: directed scoreboard bench for add_share_arbiter.
// Inputs change and outputs are sampled around the falling edge.
module tb_add_share_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req0_cin;
    logic [7:0] req0_a, req0_b;
    logic       req1_valid, req1_ready, req1_cin;
    logic [7:0] req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_cout, rsp_id;
    logic [7:0] rsp_sum;

    add_share_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_cin(req1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
        .rsp_cout(rsp_cout), .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       id;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic cin, input logic id);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        return '{sum: s[7:0], cout: s[8], id: id};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Wait (bounded) for a response, then pop and compare against the scoreboard.
    task automatic expect_rsp(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!rsp_valid && n < 10) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, rsp_valid, 1);
        chk({tag, "_sb"}, q.size(), 1);
        if (rsp_valid && q.size() > 0) begin
            e = q.pop_front();
            chk({tag, "_sum"}, rsp_sum, e.sum);
            chk({tag, "_cout"}, rsp_cout, e.cout);
            chk({tag, "_id"}, rsp_id, e.id);
        end
    endtask

    initial begin
        int   n;
        logic g, exp_g;
        logic [7:0] held;

        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h00; req0_b = 8'h00; req0_cin = 1'b0;
        req1_valid = 1'b1; req1_a = 8'h00; req1_b = 8'h00; req1_cin = 1'b0;

        // Reset state, with both requesters asking.
        @(negedge clk); @(negedge clk);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_sum", rsp_sum, 0);
        chk("rst_cout", rsp_cout, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_rdy0", req0_ready, 0);
        chk("rst_rdy1", req1_ready, 0);
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // Single request from req0, exact latency.
        req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34; req0_cin = 1'b0;
        #1;
        chk("one_rdy0", req0_ready, 1);
        chk("one_rdy1", req1_ready, 0);
        step();
        q.push_back(model(8'h12, 8'h34, 1'b0, 1'b0));
        req0_valid = 1'b0;
        chk("one_exec", rsp_valid, 0);
        step();
        chk("one_lat", rsp_valid, 1);
        expect_rsp("one");
        step();
        chk("one_idle", rsp_valid, 0);

        // Wrap-around from req1, issued in the first idle cycle.
        req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'hFF; req1_cin = 1'b1;
        #1;
        chk("wrap_rdy1", req1_ready, 1);
        step();
        q.push_back(model(8'hFF, 8'hFF, 1'b1, 1'b1));
        req1_valid = 1'b0;
        expect_rsp("wrap");
        step();

        // Contention: both valid continuously.
        req0_valid = 1'b1; req1_valid = 1'b1;
        exp_g = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req0_a = 8'h10 + 8'(k); req0_b = 8'h01; req0_cin = 1'b0;
            req1_a = 8'hC0 + 8'(k); req1_b = 8'h50; req1_cin = 1'b1;
            #1;
            n = 0;
            while (!(req0_ready || req1_ready) && n < 10) begin
                step(); #1; n++;
            end
            chk("ctn_rdy", req0_ready | req1_ready, 1);
            chk("ctn_excl", req0_ready & req1_ready, 0);
            g = req1_ready;
            chk("ctn_gnt", g, exp_g);
            q.push_back(g ? model(req1_a, req1_b, req1_cin, 1'b1)
                          : model(req0_a, req0_b, req0_cin, 1'b0));
            step();
`ifndef ADD_SHARE_ARB_FIXED_PRIO_EN
            exp_g = ~exp_g;
`endif
            expect_rsp("ctn");
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        step();

        // Backpressure: result held, no new grant until after acceptance.
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h55; req0_b = 8'h0A; req0_cin = 1'b1;
        #1;
        chk("bp_rdy0", req0_ready, 1);
        step();
        q.push_back(model(8'h55, 8'h0A, 1'b1, 1'b0));
        req0_a = 8'h01; req0_b = 8'h02; req0_cin = 1'b0;
        #1;
        chk("bp_exec_rdy0", req0_ready, 0);
        step();
        expect_rsp("bp");
        held = 8'h60;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_sum", rsp_sum, held);
            chk("bp_hold_rdy0", req0_ready, 0);
            chk("bp_hold_rdy1", req1_ready, 0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_acc_rdy0", req0_ready, 0);
        step();
        #1;
        chk("bp_after_valid", rsp_valid, 0);
        chk("bp_after_rdy0", req0_ready, 1);
        q.push_back(model(8'h01, 8'h02, 1'b0, 1'b0));
        step();
        req0_valid = 1'b0;
        expect_rsp("bp2");
        step();

        // Reset during EXEC.
        req1_valid = 1'b1; req1_a = 8'h10; req1_b = 8'h20; req1_cin = 1'b0;
        #1;
        step();
        rst = 1'b1;
        #1;
        chk("rx_valid", rsp_valid, 0);
        chk("rx_rdy1", req1_ready, 0);
        req1_valid = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Reset during RESP; req0 served last so only reset restores its tie win.
        req0_valid = 1'b1; req0_a = 8'h33; req0_b = 8'h44; req0_cin = 1'b0;
        #1;
        step();
        req0_valid = 1'b0;
        step();
        chk("rr_resp", rsp_valid, 1);
        rst = 1'b1;
        #1;
        chk("rr_valid", rsp_valid, 0);
        chk("rr_sum", rsp_sum, 0);
        chk("rr_cout", rsp_cout, 0);
        step();
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h21; req0_b = 8'h43; req0_cin = 1'b1;
        req1_valid = 1'b1; req1_a = 8'h99; req1_b = 8'h11; req1_cin = 1'b0;
        #1;
        chk("post_rdy0", req0_ready, 1);
        chk("post_rdy1", req1_ready, 0);
        q.push_back(model(8'h21, 8'h43, 1'b1, 1'b0));
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        expect_rsp("post");
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
